// File: rtl/icache_arb.sv
// rtl/icache_arb.sv - two-requester i-cache address arbiter with in-order response routing
// Round-robin arbitration when ICACHE_ARB_RR_EN is defined; fixed priority (fetch first) otherwise.
module icache_arb #(
    parameter int DEPTH  = 2,
    parameter int XLEN   = 32,
    parameter int DATA_W = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic [1:0][XLEN-1:0]   req_addr_i,
    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    output logic [1:0][DATA_W-1:0] rsp_data_o,
    output logic [1:0]             rsp_valid_o,
    input  logic [1:0]             rsp_ready_i,
    output logic [XLEN-1:0]        addr_o,
    output logic                   addr_valid_o,
    input  logic                   addr_ready_i,
    input  logic [DATA_W-1:0]      data_i,
    input  logic                   data_valid_i,
    output logic                   data_ready_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] id_q, id_d, stale_q, stale_d;
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic             lock_q, lock_d, lock_id_q, lock_id_d;
    logic [AW-1:0]    waddr, raddr;
    logic             grant, free_grant, empty, full, push, pop;
    logic             head_id, head_stale;

    assign waddr = wptr_q[AW-1:0];
    assign raddr = rptr_q[AW-1:0];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (waddr == raddr);
    assign head_id    = id_q[raddr];
    assign head_stale = stale_q[raddr];

`ifdef ICACHE_ARB_RR_EN
    logic prio_q, prio_d;

    always_comb begin
        prio_d = prio_q;
        if (push) begin
            prio_d = ~prio_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign free_grant = req_valid_i[prio_q] ? prio_q : ~prio_q;
`else
    assign free_grant = req_valid_i[0] ? 1'b0 : 1'b1;
`endif

    // Outputs are gated by reset so nothing leaks out while the state is being cleared.
    always_comb begin
        grant        = lock_q ? lock_id_q : free_grant;
        addr_o       = req_addr_i[grant];
        addr_valid_o = rst_n_i && !flush_i && !full &&
                       (lock_q ? req_valid_i[grant] : (req_valid_i != 2'b00));
        push         = addr_valid_o && addr_ready_i;
        req_ready_o  = 2'b00;
        if (push) begin
            req_ready_o[grant] = 1'b1;
        end
        data_ready_o = rst_n_i && !empty && (head_stale || rsp_ready_i[head_id]);
        rsp_valid_o  = 2'b00;
        if (rst_n_i && !empty && !head_stale) begin
            rsp_valid_o[head_id] = data_valid_i;
        end
        rsp_data_o = {data_i, data_i};
        pop        = data_valid_i && data_ready_o;
    end

    // Flush marks every slot stale; a later push rewrites its slot's stale bit to 0.
    always_comb begin
        id_d      = id_q;
        stale_d   = stale_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push) begin
            id_d[waddr]    = grant;
            stale_d[waddr] = 1'b0;
            wptr_d         = wptr_q + 1'b1;
        end
        if (flush_i) begin
            stale_d = '1;
            lock_d  = 1'b0;
        end else if (push) begin
            lock_d = 1'b0;
        end else if (addr_valid_o) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            id_q      <= '0;
            stale_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
        end else begin
            id_q      <= id_d;
            stale_q   <= stale_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

`ifndef SYNTHESIS
    a_no_data_when_empty: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        data_valid_i |-> !empty)
        else $error("data_valid_i with no outstanding read");
`endif

endmodule

// File: tb/tb_icache_arb.sv
// tb/tb_icache_arb.sv - scoreboard bench for icache_arb (directed cases plus random traffic)
module tb_icache_arb;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam int DW    = 32;

    logic                clk = 1'b0;
    logic                rst_n, flush, addr_ready, data_valid, data_ready, addr_valid;
    logic [1:0][XLEN-1:0] req_addr;
    logic [1:0][DW-1:0]  rsp_data;
    logic [1:0]          req_valid, req_ready, rsp_valid, rsp_ready;
    logic [XLEN-1:0]     addr;
    logic [DW-1:0]       data;

    always #5 clk = ~clk;

    icache_arb #(.DEPTH(DEPTH), .XLEN(XLEN), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .req_addr_i(req_addr), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .addr_o(addr), .addr_valid_o(addr_valid), .addr_ready_i(addr_ready),
        .data_i(data), .data_valid_i(data_valid), .data_ready_o(data_ready)
    );

    typedef struct {
        bit          id;
        bit          stale;
        logic [31:0] a;
    } rd_t;

    rd_t         out_q[$];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    bit          m_lock, m_lock_id, m_prio, clr_exp;
    bit   [1:0]  acc;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_F00D;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: outstanding reads as a queue, grant chosen from the arbitration rules.
    always @(negedge clk) begin
        bit g, av, dr, full, empty;
        bit [1:0] rr, rv;
        rd_t e;
        full  = out_q.size() >= DEPTH;
        empty = out_q.size() == 0;
        if (m_lock) g = m_lock_id;
        else begin
`ifdef ICACHE_ARB_RR_EN
            g = req_valid[m_prio] ? m_prio : !m_prio;
`else
            g = req_valid[0] ? 1'b0 : 1'b1;
`endif
        end
        av = rst_n && !flush && !full && (req_valid != 2'b00);
        rr = (av && addr_ready) ? (2'b01 << g) : 2'b00;
        dr = 1'b0;
        rv = 2'b00;
        if (rst_n && !empty) begin
            dr = out_q[0].stale || rsp_ready[out_q[0].id];
            if (!out_q[0].stale && data_valid) rv = 2'b01 << out_q[0].id;
        end
        chk("addr_valid", addr_valid, av);
        if (av) chk("addr", addr, req_addr[g]);
        chk("req_ready", req_ready, rr);
        chk("data_ready", data_ready, dr);
        chk("rsp_valid", rsp_valid, rv);
        acc = rr;
        if (!rst_n) begin
            out_q.delete();
            m_lock  = 1'b0;
            m_prio  = 1'b0;
            clr_exp = 1'b1;
        end else begin
            if (data_valid && dr) void'(out_q.pop_front());
            if (flush) begin
                foreach (out_q[i]) out_q[i].stale = 1'b1;
                m_lock  = 1'b0;
                clr_exp = 1'b1;
            end else if (av && addr_ready) begin
                e.id = g; e.stale = 1'b0; e.a = req_addr[g];
                out_q.push_back(e);
                if (g) exp_q1.push_back(line_of(req_addr[g]));
                else   exp_q0.push_back(line_of(req_addr[g]));
                m_lock = 1'b0;
                m_prio = !m_prio;
            end else if (av) begin
                m_lock    = 1'b1;
                m_lock_id = g;
            end
        end
    end

    always @(posedge clk) begin
        if (clr_exp) begin
            exp_q0.delete();
            exp_q1.delete();
            clr_exp = 1'b0;
        end
    end

    // Response monitor: pops the scoreboard on every accepted response beat.
    always @(negedge clk) begin
        if (rsp_valid[0] && rsp_ready[0]) begin
            if (exp_q0.size() == 0) chk("rsp0_unexpected", 1, 0);
            else chk("rsp0_data", rsp_data[0], exp_q0.pop_front());
        end
        if (rsp_valid[1] && rsp_ready[1]) begin
            if (exp_q1.size() == 0) chk("rsp1_unexpected", 1, 0);
            else chk("rsp1_data", rsp_data[1], exp_q1.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input bit v);
        data_valid = v && (out_q.size() > 0);
        data       = (out_q.size() > 0) ? line_of(out_q[0].a) : '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; req_valid = 2'b00; data_valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [1:0] seen [4];
    logic [1:0] exp_g;

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 2'b00; req_addr = '0; rsp_ready = 2'b00;
        addr_ready = 1'b0; data = '0; data_valid = 1'b0;
        step(); step();
        @(negedge clk);
        chk("rst_addr_valid", addr_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_data_ready", data_ready, 0);
        step();
        rst_n = 1'b1;

        // single fetch read, response one cycle later
        req_valid = 2'b01; req_addr[0] = 32'h100; addr_ready = 1'b1; rsp_ready = 2'b11;
        @(negedge clk);
        chk("t1_addr", addr, 32'h100);
        chk("t1_req_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00; set_data(1);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        step();
        set_data(0);

        // both requesters valid every cycle
        do_reset();
        req_valid = 2'b11; req_addr[0] = 32'h200; req_addr[1] = 32'h300;
        for (int i = 0; i < 4; i++) begin
            set_data(1);
            @(negedge clk);
            seen[i] = req_ready;
            step();
            req_addr[0] = req_addr[0] + 4; req_addr[1] = req_addr[1] + 4;
        end
        for (int i = 0; i < 4; i++) begin
`ifdef ICACHE_ARB_RR_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            chk("grant_seq", seen[i], exp_g);
        end
        req_valid = 2'b00; set_data(0);

        // grant lock while the i-cache stalls
        do_reset();
        req_valid = 2'b10; req_addr[1] = 32'h440; req_addr[0] = 32'h400; addr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lock_addr", addr, 32'h440);
            chk("lock_req_ready", req_ready, 2'b00);
            step();
            req_valid = 2'b11;
        end
        addr_ready = 1'b1;
        @(negedge clk);
        chk("lock_hs_addr", addr, 32'h440);
        chk("lock_hs_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b01;
        @(negedge clk);
        chk("after_lock_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;

        // FIFO full blocks requests; no same-cycle bypass
        do_reset();
        rsp_ready = 2'b11; addr_ready = 1'b1; req_valid = 2'b01; req_addr[0] = 32'h500;
        step(); req_addr[0] = 32'h504;
        step(); req_addr[0] = 32'h508;
        @(negedge clk);
        chk("full_addr_valid", addr_valid, 0);
        chk("full_req_ready", req_ready, 2'b00);
        step();
        set_data(1);
        @(negedge clk);
        chk("nobypass_addr_valid", addr_valid, 0);
        chk("nobypass_data_ready", data_ready, 1);
        step();
        set_data(0);
        @(negedge clk);
        chk("refill_addr_valid", addr_valid, 1);
        step();
        req_valid = 2'b00;

        // flush drops outstanding lines
        do_reset();
        addr_ready = 1'b1; req_valid = 2'b01; req_addr[0] = 32'h600;
        step(); req_addr[0] = 32'h604;
        step(); req_valid = 2'b00; flush = 1'b1;
        step(); flush = 1'b0; rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            set_data(1);
            @(negedge clk);
            chk("stale_data_ready", data_ready, 1);
            chk("stale_rsp_valid", rsp_valid, 2'b00);
            step();
        end
        set_data(0); rsp_ready = 2'b11;
        @(negedge clk);
        chk("flush_empty", data_ready, 0);
        step();

        // reset in the middle of a transaction
        do_reset();
        req_valid = 2'b01; req_addr[0] = 32'h700; addr_ready = 1'b1;
        step();
        rst_n = 1'b0; req_valid = 2'b11;
        @(negedge clk);
        chk("midrst_addr_valid", addr_valid, 0);
        chk("midrst_req_ready", req_ready, 2'b00);
        chk("midrst_data_ready", data_ready, 0);
        chk("midrst_rsp_valid", rsp_valid, 2'b00);
        step();
        rst_n = 1'b1; req_valid = 2'b00;
        @(negedge clk);
        chk("postrst_data_ready", data_ready, 0);
        chk("postrst_rsp_valid", rsp_valid, 2'b00);
        step();

        // random traffic; requesters hold their address until accepted
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] || acc[r]) begin
                    req_valid[r] = ($urandom_range(0, 99) < 60);
                    req_addr[r]  = $urandom & 32'hFFFF_FFFC;
                end
            end
            addr_ready = ($urandom_range(0, 3) != 0);
            rsp_ready  = 2'($urandom_range(0, 3));
            flush      = ($urandom_range(0, 29) == 0);
            rst_n      = ($urandom_range(0, 499) != 0);
            set_data(rst_n && ($urandom_range(0, 1) == 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_arb.md
ICACHE_ARB -- requirements
Module: icache_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 2: maximum number of outstanding i-cache reads; power of two, at least 2.
REQ-002 SHALL have port clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n_i  in  1  synchronous, active-low reset.
REQ-004 SHALL have port flush_i  in  1  pipeline flush; marks all outstanding reads stale.
REQ-005 SHALL have port req_addr_i  in  2 x XLEN  fetch address per requester; index 0 = fetch (icache_ifc), index 1 = prefetcher.
REQ-006 SHALL have port req_valid_i  in  2  address valid per requester.
REQ-007 SHALL have port req_ready_o  out  2  address accepted per requester.
REQ-008 SHALL have port rsp_data_o  out  2 x icache_out_t  returned cache line per requester.
REQ-009 SHALL have port rsp_valid_o  out  2  response valid per requester.
REQ-010 SHALL have port rsp_ready_i  in  2  requester ready for response.
REQ-011 SHALL have port addr_o  out  XLEN  address to i-cache.
REQ-012 SHALL have port addr_valid_o  out  1  address valid to i-cache.
REQ-013 SHALL have port addr_ready_i  in  1  i-cache accepts address.
REQ-014 SHALL have port data_i  in  icache_out_t  i-cache read data.
REQ-015 SHALL have port data_valid_i  in  1  i-cache data valid.
REQ-016 SHALL have port data_ready_o  out  1  arbiter accepts data.

Function
REQ-017 SHALL grant at most one requester per cycle; addr_o = req_addr_i[grant]; addr_valid_o = 1 only when some req_valid_i = 1, the ID FIFO is not full, and flush_i = 0.
REQ-018 SHALL assert req_ready_o[g] = 1 only for the granted g, when addr_valid_o = 1 and addr_ready_i = 1; the other bit SHALL be 0.
REQ-019 SHALL lock the grant while addr_valid_o = 1 and addr_ready_i = 0; addr_o and grant SHALL stay stable until the handshake completes or flush_i rises.
REQ-020 SHALL push {grant, stale = 0} into a DEPTH-entry in-order ID FIFO on each address handshake.
REQ-021 SHALL NOT bypass: full status SHALL be evaluated at cycle start, so a pop in the same cycle does not free a slot for a push.
REQ-022 SHALL, when the FIFO head is non-stale, drive rsp_valid_o[head.id] = data_valid_i and rsp_data_o[head.id] = data_i; data_ready_o = rsp_ready_i[head.id].
REQ-023 SHALL, when the head is stale, drive data_ready_o = 1 with both rsp_valid_o bits 0, silently dropping the line.
REQ-024 SHALL pop the FIFO head on data_valid_i & data_ready_o; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-025 SHALL drive data_ready_o = 0 when the FIFO is empty; data_valid_i with an empty FIFO is a protocol error, flagged by a simulation-only assertion.
REQ-026 SHALL, on flush_i = 1, set stale = 1 for every entry still present after that cycle's pop, clear the lock, and issue no new address that cycle.
REQ-027 SHALL drive all requests inactive when the FIFO is full: addr_valid_o = 0 and both req_ready_o bits 0.

Reset
REQ-028 SHALL, while rst_n_i = 0 at a clock edge, empty the FIFO (pointers 0, all stale bits 0), clear the lock, and set the priority pointer to 0.
REQ-029 SHALL drive, during and after reset until new activity: addr_valid_o = 0, req_ready_o = 00, rsp_valid_o = 00, data_ready_o = 0.

Configuration
REQ-030 SHALL, with ICACHE_ARB_RR_EN defined, arbitrate round-robin: priority pointer toggles to the other requester after each address handshake.
REQ-031 SHALL, without ICACHE_ARB_RR_EN, use fixed priority with fetch (0) over prefetch (1); no priority-pointer flop is instantiated.

Verification
REQ-032 SHALL cover: only req 0 valid, addr 0x100, addr_ready_i = 1 -> addr_o = 0x100 at cycle 0, req_ready_o = 01; data 1 cycle later -> rsp_valid_o = 01.
REQ-033 SHALL cover: both valid every cycle, addr_ready_i = 1 -> RR grants 0,1,0,1; fixed priority grants 0,0,0,0.
REQ-034 SHALL cover: addr_ready_i = 0 for 3 cycles with req 1 granted while req 0 rises -> addr_o holds req 1's address until the handshake.
REQ-035 SHALL cover: DEPTH = 2, two reads issued with no data -> third request sees addr_valid_o = 0; one data beat -> addr_valid_o returns 1 the next cycle.
REQ-036 SHALL cover: two outstanding reads, then flush_i pulse, then two data beats -> data_ready_o = 1 on both, rsp_valid_o = 00, FIFO empty afterwards.
REQ-037 SHALL cover: rst_n_i = 0 mid-transaction with one outstanding read -> next cycle all outputs low, FIFO empty.
